// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared opcodes, FSM state encoding and multiply helpers for the
//            RV32M multiply/divide sequencer.
// Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'b00100;
    localparam logic [4:0] OP_MULH   = 5'b00101;
    localparam logic [4:0] OP_MULHU  = 5'b00110;
    localparam logic [4:0] OP_MULHSU = 5'b00111;
    localparam logic [4:0] OP_DIV    = 5'b01000;
    localparam logic [4:0] OP_DIVU   = 5'b01001;
    localparam logic [4:0] OP_REM    = 5'b01010;
    localparam logic [4:0] OP_REMU   = 5'b01011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic is_mdu_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    // Full 64-bit product; operand extension depends on the opcode.
    // MUL only keeps the low half, which is identical for any extension.
    function automatic logic [63:0] mul_full(input logic [4:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
        logic [63:0] ext_a;
        logic [63:0] ext_b;
        ext_a = (op == OP_MULHU) ? {32'b0, a} : {{32{a[XLEN-1]}}, a};
        ext_b = ((op == OP_MUL) || (op == OP_MULH)) ? {{32{b[XLEN-1]}}, b} : {32'b0, b};
        return ext_a * ext_b;
    endfunction

    function automatic logic [XLEN-1:0] mul_select(input logic [4:0] op,
                                                   input logic [63:0] prod);
        return (op == OP_MUL) ? prod[31:0] : prod[63:32];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational radix-2 restoring division step. Shifts the
//            next dividend bit into the partial remainder and trial-subtracts
//            the divisor using 33-bit arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module div_step
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_shift,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_shift,
    output logic            o_qbit
);

    logic [XLEN:0] w_trial;
    logic [XLEN:0] w_diff;

    assign w_trial = {i_rem, i_shift[XLEN-1]};
    assign w_diff  = w_trial - {1'b0, i_divisor};
    // Non-negative difference means the divisor fits: quotient bit is 1
    assign o_qbit  = ~w_diff[XLEN];
    // Partial remainder is always below the divisor, so 32 bits suffice
    assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
    // Vacated LSB receives the quotient bit in the caller
    assign o_shift = {i_shift[XLEN-2:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : Multi-cycle RV32M controller. Fixed-latency registered multiply
//            path and an iterative restoring divider with RISC-V corner cases.
// Revision : 1.0  initial release
// ============================================================================
module mdu_sequencer #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        kill,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);
    import mdu_pkg::*;

    state_t          r_state;
    state_t          w_next_state;
    logic [4:0]      r_cnt;
    logic [4:0]      r_op;
    logic [XLEN-1:0] r_shift;   // dividend magnitude, becomes the quotient
    logic [XLEN-1:0] r_div;     // divisor magnitude
    logic [XLEN-1:0] r_rem;
    logic            r_qneg;
    logic            r_rneg;
    logic [63:0]     r_prod;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_is_mdu;
    logic            w_is_mul;
    logic            w_accept;
    logic            w_signed_div;
    logic            w_is_rem;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_direct;
    logic [XLEN-1:0] w_special_res;
    logic [63:0]     w_prod;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_shift_nxt;
    logic            w_qbit;
    logic [XLEN-1:0] w_fix_q;
    logic [XLEN-1:0] w_fix_r;

    assign w_is_mdu     = is_mdu_op(opcode);
    assign w_is_mul     = w_is_mdu && (opcode <= OP_MULHSU);
    assign w_accept     = (r_state == S_IDLE) && start && w_is_mdu && !kill;
    assign w_signed_div = (opcode == OP_DIV) || (opcode == OP_REM);
    assign w_is_rem     = (opcode == OP_REM) || (opcode == OP_REMU);
    assign w_div_zero   = (data2 == 32'h0);
    assign w_div_ovf    = w_signed_div && (data1 == 32'h8000_0000) && (data2 == 32'hFFFF_FFFF);
    // Operations that finish on the accept edge and never raise busy
    assign w_direct     = w_is_mul ? (MUL_CYCLES == 1) : (w_div_zero || w_div_ovf);

    assign w_special_res = w_div_zero ? (w_is_rem ? data1 : 32'hFFFF_FFFF)
                                      : (w_is_rem ? 32'h0 : 32'h8000_0000);

    assign w_prod = mul_full(opcode, data1, data2);
    assign w_mag1 = (w_signed_div && data1[31]) ? (32'h0 - data1) : data1;
    assign w_mag2 = (w_signed_div && data2[31]) ? (32'h0 - data2) : data2;

    div_step u_div_step (
        .i_rem     (r_rem),
        .i_shift   (r_shift),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_shift   (w_shift_nxt),
        .o_qbit    (w_qbit)
    );

    assign w_fix_q = r_qneg ? (32'h0 - r_shift) : r_shift;
    assign w_fix_r = r_rneg ? (32'h0 - r_rem)   : r_rem;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign stall  = r_busy || ((r_state == S_IDLE) && start && w_is_mdu);

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode; kill aborts every working state but not DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_direct)      w_next_state = S_DONE;
                    else if (w_is_mul) w_next_state = S_MUL;
                    else               w_next_state = S_DIV;
                end
            end
            S_MUL: begin
                if (kill)               w_next_state = S_IDLE;
                else if (r_cnt <= 5'd1) w_next_state = S_DONE;
            end
            S_DIV: begin
                if (kill)               w_next_state = S_IDLE;
                else if (r_cnt == 5'd0) w_next_state = S_FIX;
            end
            S_FIX:   w_next_state = kill ? S_IDLE : S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath, counter and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt    <= 5'd0;
            r_op     <= 5'd0;
            r_shift  <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_prod   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= opcode;
                        r_busy <= !w_direct;
                        if (w_is_mul) begin
                            r_cnt  <= 5'(MUL_CYCLES - 1);
                            r_prod <= w_prod;
                            if (w_direct) begin
                                r_result <= mul_select(opcode, w_prod);
                                r_done   <= 1'b1;
                            end
                        end else if (w_direct) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                        end else begin
                            r_cnt   <= 5'd31;
                            r_shift <= w_mag1;
                            r_div   <= w_mag2;
                            r_rem   <= '0;
                            r_qneg  <= w_signed_div && (data1[31] ^ data2[31]);
                            r_rneg  <= w_signed_div && data1[31];
                        end
                    end
                end
                S_MUL: begin
                    // The accept edge already spent one multiply cycle, so
                    // the result commits one count before the counter empties
                    if (kill) begin
                        r_busy <= 1'b0;
                    end else if (r_cnt <= 5'd1) begin
                        r_result <= mul_select(r_op, r_prod);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DIV: begin
                    if (kill) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_rem   <= w_rem_nxt;
                        r_shift <= w_shift_nxt | {31'b0, w_qbit};
                        if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (!kill) begin
                        r_result <= ((r_op == OP_REM) || (r_op == OP_REMU)) ? w_fix_r : w_fix_q;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle controller for the RV32M multiply/divide operations (ALU opcodes 00100..01011), so they no longer sit in one combinational EX stage.
- Sits beside the ALU in EX. Accepts one operation per start pulse, stalls the pipeline while working, and returns one registered 32-bit result with a done pulse.
- Multiplies run on a fixed-latency registered path. Divides/remainders run on an iterative radix-2 restoring divider, with RISC-V corner-case handling.

Parameters:
- MUL_CYCLES, 2, cycles from accepted start to done for MUL/MULH/MULHU/MULHSU. Legal range 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  request strobe from EX, sampled in IDLE only.
- opcode  input  5  ALU opcode; same encoding as the ALU.
- data1  input  32  rs1 operand (dividend / multiplicand).
- data2  input  32  rs2 operand (divisor / multiplier).
- kill  input  1  pipeline flush; aborts any operation in flight.
- busy  output  1  registered; high from the cycle after accept until done.
- stall  output  1  combinational; busy OR (state==IDLE AND start AND opcode in 00100..01011).
- done  output  1  registered single-cycle pulse; result valid.
- result  output  32  registered result; held until the next done.

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, result=0, iteration counter=0, operand/remainder/quotient registers=0.
- Accept condition: IDLE AND start AND opcode in 00100..01011 AND NOT kill.
  - Other opcodes are ignored: no busy, no stall.
  - start while not IDLE is ignored.
- Operand capture: operands and opcode are captured on accept. Later changes on data1/data2/opcode have no effect.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE -> MUL: accepted multiply. Counter loads MUL_CYCLES-1.
  - Full 64-bit product is registered: signed x signed, unsigned x unsigned, or signed data1 x unsigned data2.
  - Select: MUL=[31:0]; MULH/MULHU/MULHSU=[63:32].
- MUL -> DONE: when counter==0; otherwise decrement. done is asserted exactly MUL_CYCLES cycles after the accept edge.
- IDLE -> DONE (one cycle) for division special cases:
  - Divide by zero: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=data1.
  - Signed overflow (DIV/REM, data1=0x80000000, data2=0xFFFFFFFF): DIV result=0x80000000, REM result=0.
- IDLE -> DIV: all other divides.
  - Signed ops take magnitudes and record quotient sign (sign1 XOR sign2) and remainder sign (sign1).
  - 32 iterations, one quotient bit per cycle, MSB first. Counter 31 down to 0.
- DIV -> FIX: after iteration with counter==0.
- FIX -> DONE: applies sign correction (two's-complement negate) and selects quotient or remainder.
  - Normal divide latency: done 34 cycles after accept.
- DONE -> IDLE: unconditionally next cycle.
  - result updated and done=1 for that single cycle. busy=0 in the same cycle as done.
  - A new start is accepted in the cycle after done, back-to-back.
- kill:
  - In any non-IDLE state, next state=IDLE, busy=0, no done, result unchanged.
  - kill in the same cycle as start blocks acceptance.
  - kill in DONE still lets that done pulse complete (result already committed).
- RESET mid-operation: immediate return to reset values; no done.
- Arithmetic:
  - All internal shifts and subtracts are 33-bit; quotient/remainder registers are 32-bit.
  - Unsigned ops never negate.
- result on non-done cycles keeps its last value.

Decomposition:
- Shared package (mdu_pkg): opcode constants OP_MUL=5'b00100, OP_MULH=00101, OP_MULHU=00110, OP_MULHSU=00111, OP_DIV=01000, OP_DIVU=01001, OP_REM=01010, OP_REMU=01011; state encoding localparams; XLEN=32.
- One sub-module: div_step, combinational restoring step. Inputs: partial remainder, dividend shift register, divisor. Outputs: next remainder, next shift register, quotient bit.
- Top level holds the FSM, counter, product register and sign fixup.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), MUL_CYCLES=2 -> done 2 cycles after accept, result=0xFFFFFFEB; stall high on the accept cycle and the following cycle.
- MULH/MULHU/MULHSU, each with data1=data2=0xFFFFFFFF -> results 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF respectively.
- DIV 0xFFFFFFF9 (-7) / 2 -> done 34 cycles after accept, 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; each done 1 cycle after accept.
- Start DIV 1000/3, assert kill 10 cycles after accept -> busy=0 next cycle, no done, result unchanged. Immediate new DIVU 9/3 -> 3 at +34.
- Assert RESET 5 cycles into a DIV -> busy/done/result=0 asynchronously. Opcode 00000 with start -> no stall, no busy. start during busy -> ignored.
